led_blink_divider: RTL and testbench

- Multi-channel LED blink generator driven by one shared free-running counter.
- Each channel has its own rate select and output mode: off, on, square blink, or short-flash pulse.
- Rate changes take effect only at a common superperiod boundary, so outputs never produce truncated pulses.
- Sits between board switches/control logic and the LED pins.

---
 rtl/led_blink_divider.sv | 114 +++++++++++
 tb/tb_led_blink_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_divider.sv
//==============================================================================
// Module   : led_blink_divider
// Brief    : Multi-channel LED blink generator sharing one free-running counter.
//            Optional macro LED_BLINK_SEL_SYNC_EN adds 2-flop synchronizers on mode/sel.
// Revision : 1.0
//==============================================================================
`default_nettype none

module led_blink_divider #(
    parameter int CNT_W  = 23,
    parameter int NCH    = 4,
    parameter int SEL_W  = 2,
    parameter int TAP_LO = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NCH-1:0]       mode,
    input  logic [SEL_W*NCH-1:0]   sel,
    output logic [NCH-1:0]         out,
    output logic                   tick
);

    localparam int TAP_HI = TAP_LO + (1 << SEL_W) - 1;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PULSE = 2'b11;

    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [SEL_W-1:0]     active_sel_q [NCH];
    logic [SEL_W-1:0]     active_sel_d [NCH];
    logic [1:0]           tap_pair     [NCH];
    logic [NCH-1:0]       out_q;
    logic [NCH-1:0]       out_d;
    logic                 tick_q;
    logic                 tick_d;
    logic                 boundary;
    logic [2*NCH-1:0]     mode_use;
    logic [SEL_W*NCH-1:0] sel_use;

`ifdef LED_BLINK_SEL_SYNC_EN
    logic [2*NCH-1:0]     mode_s1_q;
    logic [2*NCH-1:0]     mode_s2_q;
    logic [SEL_W*NCH-1:0] sel_s1_q;
    logic [SEL_W*NCH-1:0] sel_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_s1_q <= '0;
            mode_s2_q <= '0;
            sel_s1_q  <= '0;
            sel_s2_q  <= '0;
        end else begin
            mode_s1_q <= mode;
            mode_s2_q <= mode_s1_q;
            sel_s1_q  <= sel;
            sel_s2_q  <= sel_s1_q;
        end
    end

    assign mode_use = mode_s2_q;
    assign sel_use  = sel_s2_q;
`else
    assign mode_use = mode;
    assign sel_use  = sel;
`endif

    // All tap bits are one here, so every channel restarts at phase 0 next cycle.
    assign boundary = &cnt_q[TAP_HI:0];
    assign cnt_d    = cnt_q + CNT_W'(1);
    assign tick_d   = boundary;

    always_comb begin
        out_d = '0;
        for (int i = 0; i < NCH; i++) begin
            active_sel_d[i] = boundary ? sel_use[SEL_W*i +: SEL_W] : active_sel_q[i];
            // bit 1 = cnt[t], bit 0 = cnt[t-1] for the channel's current tap t
            tap_pair[i] = 2'(cnt_q >> (TAP_LO - 1 + int'(active_sel_q[i])));
            case (mode_use[2*i +: 2])
                MODE_OFF:   out_d[i] = 1'b0;
                MODE_ON:    out_d[i] = 1'b1;
                MODE_BLINK: out_d[i] = tap_pair[i][1];
                MODE_PULSE: out_d[i] = tap_pair[i][1] & tap_pair[i][0];
                default:    out_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= '0;
            tick_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                active_sel_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            for (int i = 0; i < NCH; i++) begin
                active_sel_q[i] <= active_sel_d[i];
            end
        end
    end

    assign out  = out_q;
    assign tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_led_blink_divider.sv
//==============================================================================
// Module   : tb_led_blink_divider
// Brief    : Self-checking bench for led_blink_divider (CNT_W=8, TAP_LO=1).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_led_blink_divider;

    localparam int CNT_W  = 8;
    localparam int NCH    = 4;
    localparam int SEL_W  = 2;
    localparam int TAP_LO = 1;

`ifdef LED_BLINK_SEL_SYNC_EN
    localparam int         LAT   = 2;
    localparam logic [3:0] EXP5  = 4'h0;
    localparam logic [3:0] EXP9  = 4'h4;
    localparam logic [3:0] EXP40 = 4'h2;
    localparam logic [3:0] EXP68 = 4'h0;
`else
    localparam int         LAT   = 0;
    localparam logic [3:0] EXP5  = 4'h4;
    localparam logic [3:0] EXP9  = 4'h0;
    localparam logic [3:0] EXP40 = 4'hA;
    localparam logic [3:0] EXP68 = 4'h8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mode = '0;
    logic [7:0] sel  = '0;
    logic [3:0] out;
    logic       tick;

    led_blink_divider #(
        .CNT_W  (CNT_W),
        .NCH    (NCH),
        .SEL_W  (SEL_W),
        .TAP_LO (TAP_LO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .sel  (sel),
        .out  (out),
        .tick (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        bit         upd;
        logic [7:0] mode;
        logic [7:0] sel;
        bit         chk;
        logic [3:0] out;
        logic       tick;
    } vec_t;

    typedef struct {
        int         k;
        logic [3:0] out;
        logic       tick;
    } exp_t;

    vec_t       tbl [16];
    int         ntbl = 0;
    exp_t       sb [$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] hist_mode [0:127];
    logic [7:0] hist_sel  [0:127];
    logic [1:0] m_as      [NCH];

    task automatic add(input int k, input bit upd, input logic [7:0] m, input logic [7:0] s,
                       input bit chk, input logic [3:0] o, input logic t);
        tbl[ntbl] = '{k: k, upd: upd, mode: m, sel: s, chk: chk, out: o, tick: t};
        ntbl++;
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    // Reference: cnt before edge k is k-1; rate latches at each 32-cycle boundary.
    task automatic model_push(input int k);
        logic [7:0] em;
        logic [7:0] es;
        logic [3:0] eo;
        logic       et;
        int         c;
        int         t;
        em = (k - LAT >= 1) ? hist_mode[k-LAT] : 8'h00;
        es = (k - LAT >= 1) ? hist_sel[k-LAT]  : 8'h00;
        c  = (k - 1) % 256;
        eo = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            t = TAP_LO + int'(m_as[ch]);
            case (em[2*ch +: 2])
                2'b00: eo[ch] = 1'b0;
                2'b01: eo[ch] = 1'b1;
                2'b10: eo[ch] = ((c >> t) & 1) == 1;
                2'b11: eo[ch] = (((c >> t) & (c >> (t - 1))) & 1) == 1;
                default: eo[ch] = 1'b0;
            endcase
        end
        et = ((c % 32) == 31);
        sb.push_back('{k: k, out: eo, tick: et});
        if (et) begin
            for (int ch = 0; ch < NCH; ch++) m_as[ch] = es[2*ch +: 2];
        end
    endtask

    task automatic do_edge(input int k, input bit use_tbl);
        exp_t e;
        if (use_tbl) begin
            for (int i = 0; i < ntbl; i++) begin
                if (tbl[i].k == k && tbl[i].upd) begin
                    mode = tbl[i].mode;
                    sel  = tbl[i].sel;
                end
            end
        end
        hist_mode[k] = mode;
        hist_sel[k]  = sel;
        model_push(k);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", k, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("out", e.k, 32'(out), 32'(e.out));
            check("tick", e.k, 32'(tick), 32'(e.tick));
        end
        if (use_tbl) begin
            for (int i = 0; i < ntbl; i++) begin
                if (tbl[i].k == k && tbl[i].chk) begin
                    check("vec_out", k, 32'(out), 32'(tbl[i].out));
                    check("vec_tick", k, 32'(tick), 32'(tbl[i].tick));
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        add(1,  1, 8'h8E, 8'h84, 1, 4'h0,  1'b0);
        add(3,  0, 8'h00, 8'h00, 1, 4'h9,  1'b0);
        add(4,  0, 8'h00, 8'h00, 1, 4'hB,  1'b0);
        add(5,  1, 8'h9E, 8'h84, 1, EXP5,  1'b0);
        add(9,  1, 8'h8E, 8'h84, 1, EXP9,  1'b0);
        add(10, 1, 8'h8E, 8'h87, 0, 4'h0,  1'b0);
        add(31, 1, 8'h8E, 8'h47, 0, 4'h0,  1'b0);
        add(32, 0, 8'h00, 8'h00, 1, 4'hB,  1'b1);
        add(33, 0, 8'h00, 8'h00, 1, 4'h0,  1'b0);
        add(40, 0, 8'h00, 8'h00, 1, EXP40, 1'b0);
        add(49, 0, 8'h00, 8'h00, 1, 4'h1,  1'b0);
        add(50, 1, 8'hCE, 8'hC7, 0, 4'h0,  1'b0);
        add(63, 1, 8'hCE, 8'h07, 0, 4'h0,  1'b0);
        add(64, 0, 8'h00, 8'h00, 1, 4'hB,  1'b1);
        add(65, 0, 8'h00, 8'h00, 1, 4'h0,  1'b0);
        add(68, 0, 8'h00, 8'h00, 1, EXP68, 1'b0);

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_out", 0, 32'(out), 32'd0);
        check("rst_tick", 0, 32'(tick), 32'd0);
        check("rst_cnt", 0, 32'(dut.cnt_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int ch = 0; ch < NCH; ch++) m_as[ch] = '0;
        for (int k = 1; k <= 85; k++) do_edge(k, 1'b1);

        // Mid-cycle reset while ch0 is high at its slowest rate.
        check("pre_rst_out0", 85, 32'(out[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out", 85, 32'(out), 32'd0);
        check("mid_rst_tick", 85, 32'(tick), 32'd0);
        check("mid_rst_cnt", 85, 32'(dut.cnt_q), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int ch = 0; ch < NCH; ch++) m_as[ch] = '0;
        for (int k = 1; k <= 40; k++) do_edge(k, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
